// File: rtl/sap1_pkg.sv
// sap1_pkg: opcodes, control-bit positions, control words and T-state encoding
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CP = 11;
    localparam int EP = 10;
    localparam int LM = 9;
    localparam int CE = 8;
    localparam int LI = 7;
    localparam int EI = 6;
    localparam int LA = 5;
    localparam int EA = 4;
    localparam int SU = 3;
    localparam int EU = 2;
    localparam int LB = 1;
    localparam int LO = 0;

    localparam logic [11:0] CW_T1   = 12'(1 << EP | 1 << LM);
    localparam logic [11:0] CW_T2   = 12'(1 << CP);
    localparam logic [11:0] CW_T3   = 12'(1 << CE | 1 << LI);
    localparam logic [11:0] CW_MAR  = 12'(1 << EI | 1 << LM);
    localparam logic [11:0] CW_LDA  = 12'(1 << CE | 1 << LA);
    localparam logic [11:0] CW_LDB  = 12'(1 << CE | 1 << LB);
    localparam logic [11:0] CW_ADD  = 12'(1 << EU | 1 << LA);
    localparam logic [11:0] CW_SUB  = 12'(1 << SU | 1 << EU | 1 << LA);
    localparam logic [11:0] CW_OUT  = 12'(1 << EA | 1 << LO);
    localparam logic [11:0] CW_NONE = 12'h000;

    typedef enum logic [2:0] {S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;

    function automatic logic [5:0] state_onehot(state_t s);
        return s == S_HALT ? 6'b0 : 6'(1) << s;
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: T1..T6 ring with a sticky HALT state; one-hot and halted outputs are registered
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       clear_to_halt,
    output logic [5:0] tstate,
    output logic       halted
);

    state_t     state_q, state_d;
    logic [5:0] tstate_q, tstate_d;
    logic       halted_q, halted_d;

    always_comb begin
        state_d = state_q;
        if (clear_to_halt)
            state_d = S_HALT;
        else if (advance && state_q != S_HALT)
            state_d = state_q == S_T6 ? S_T1 : state_t'(state_q + 3'd1);
        tstate_d = state_onehot(state_d);
        halted_d = state_d == S_HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_T1;
            tstate_q <= 6'b000001;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    assign tstate = tstate_q;
    assign halted = halted_q;

endmodule

// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 controller-sequencer; decodes T-state and opcode into the datapath control word
module sap1_controller
    import sap1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic [5:0]  tstate,
    output logic        halted
);

    logic        live, is_lda, is_add, is_sub, is_out, is_mem;
    logic [11:0] t4_word, t5_word, t6_word, decode;

    sap1_ring_counter u_ring (
        .clk          (clk),
        .reset        (reset),
        .advance      (live),
        .clear_to_halt(live && tstate[3] && opcode == OP_HLT),
        .tstate       (tstate),
        .halted       (halted)
    );

    always_comb begin
        live    = run && !halted;
        is_lda  = opcode == OP_LDA;
        is_add  = opcode == OP_ADD;
        is_sub  = opcode == OP_SUB;
        is_out  = opcode == OP_OUT;
        is_mem  = is_lda || is_add || is_sub;
        t4_word = is_mem ? CW_MAR : is_out ? CW_OUT : CW_NONE;
        t5_word = is_lda ? CW_LDA : (is_add || is_sub) ? CW_LDB : CW_NONE;
        t6_word = is_add ? CW_ADD : is_sub ? CW_SUB : CW_NONE;
        // opcode is only trusted from T4 on, after the IR has loaded
        decode  = tstate[0] ? CW_T1 :
                  tstate[1] ? CW_T2 :
                  tstate[2] ? CW_T3 :
                  tstate[3] ? t4_word :
                  tstate[4] ? t5_word :
                  tstate[5] ? t6_word : CW_NONE;
        con     = decode & {12{live}};
    end

endmodule

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: directed and random stimulus against an instruction-level reference model
module tb_sap1_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [11:0] con;
    logic [5:0]  tstate;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int m_t = 1;
    bit m_h = 1'b0;

    sap1_controller dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .opcode(opcode),
        .con   (con),
        .tstate(tstate),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %h expected %h", tag, m_t, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_con(int t, bit h, bit rn, logic [3:0] op);
        if (!rn || h) return 12'h000;
        case (t)
            1: return 12'h600;
            2: return 12'h800;
            3: return 12'h180;
            4: return (op <= 4'h2) ? 12'h240 : (op == 4'hE) ? 12'h011 : 12'h000;
            5: return (op == 4'h0) ? 12'h120 : (op == 4'h1 || op == 4'h2) ? 12'h102 : 12'h000;
            6: return (op == 4'h1) ? 12'h024 : (op == 4'h2) ? 12'h02C : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    // apply inputs for one cycle, check the settled outputs, then advance the model across the edge
    task automatic step(input bit r, input bit rn, input logic [3:0] op);
        @(negedge clk);
        reset = r;
        run = rn;
        opcode = op;
        #1;
        chk("con", con, exp_con(m_t, m_h, rn, op));
        chk("tstate", {6'b0, tstate}, m_h ? 12'h0 : 12'(1 << (m_t - 1)));
        chk("halted", {11'b0, halted}, {11'b0, m_h});
        @(posedge clk);
        if (r) begin
            m_t = 1;
            m_h = 1'b0;
        end else if (rn && !m_h) begin
            if (m_t == 4 && op == 4'hF) m_h = 1'b1;
            else m_t = m_t % 6 + 1;
        end
    endtask

    task automatic instr(input logic [3:0] op);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, op);
    endtask

    int cp_count;
    logic [3:0] rop;

    initial begin
        step(1'b1, 1'b1, 4'h0);
        instr(4'h0);
        instr(4'h1);
        instr(4'h2);
        instr(4'hE);
        instr(4'h7);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        cp_count = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'h0);
            if (con[11]) cp_count++;
        end
        chk("cp_once", 12'(cp_count), 12'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h1);
        step(1'b1, 1'b1, 4'h1);
        instr(4'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)), 4'hF);
        step(1'b1, 1'b0, 4'hF);
        instr(4'h2);
        rop = 4'h0;
        for (int i = 0; i < 600; i++) begin
            if (m_t == 1 || m_h) begin
                case ($urandom_range(0, 9))
                    0, 1:    rop = 4'h0;
                    2, 3:    rop = 4'h1;
                    4, 5:    rop = 4'h2;
                    6:       rop = 4'hE;
                    7:       rop = 4'hF;
                    default: rop = 4'($urandom_range(3, 13));
                endcase
            end
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0), rop);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
